cdb_arbiter: RTL

Shares the single writeback (CDB) port of the commit/dispatch subsystem among `FU_NUM` functional-unit result producers. Each requester has a one-entry holding slot. A round-robin arbiter selects one slot per cycle into a registered CDB output stage that obeys the downstream `wb_valid`/`wb_ready` handshake. Slots and the output stage are squashed on flush and on epoch change, so stale results never reach the ROB, PRF or RS.

---
 rtl/cdb_pkg.sv | 28 ++
 rtl/cdb_arbiter_rr.sv | 46 ++++
 rtl/cdb_arbiter.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/cdb_pkg.sv
// cdb_pkg: shared types and defaults for the CDB writeback arbiter.
//   FU_NUM     - default number of functional-unit result producers
//   ROB_W      - default ROB index width
//   PHYS_W     - default physical register index width
//   DW         - default result data width
//   cdb_pkt_t  - one broadcast packet at the default widths
//   out_state_t- occupancy of the registered CDB output stage
package cdb_pkg;

   localparam int unsigned FU_NUM = 4;
   localparam int unsigned ROB_W  = 4;
   localparam int unsigned PHYS_W = 6;
   localparam int unsigned DW     = 32;

   typedef struct packed {
      logic [ROB_W-1:0]  rob_idx;
      logic [1:0]        epoch;
      logic              mispredict;
      logic [PHYS_W-1:0] pd;
      logic [DW-1:0]     data;
   } cdb_pkt_t;

   typedef enum logic {
      OUT_EMPTY = 1'b0,
      OUT_FULL  = 1'b1
   } out_state_t;

endpackage

// File: rtl/cdb_arbiter_rr.sv
// rr_arbiter: round-robin pick with an optional priority subset.
//   req       in  NUM_REQ  candidate requests
//   prio      in  NUM_REQ  priority subset; if any req&prio bit is set, only
//                          those compete
//   ptr       in  IDX_W    highest-priority requester index
//   grant     out NUM_REQ  one-hot grant
//   grant_idx out IDX_W    index of the granted requester
//   grant_valid out 1      a grant was issued
module rr_arbiter #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [NUM_REQ-1:0] prio,
   input  logic [IDX_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDX_W-1:0]   grant_idx,
   output logic               grant_valid
);

   logic [NUM_REQ-1:0] cand;
   logic [IDX_W:0]     pos;

   always_comb begin
      cand        = ((req & prio) != '0) ? (req & prio) : req;
      grant       = '0;
      grant_idx   = '0;
      grant_valid = 1'b0;
      pos         = '0;
      // Walk ptr, ptr+1, ... with wrap; the first candidate seen wins.
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         pos = {1'b0, ptr} + (IDX_W+1)'(k);
         if (pos >= (IDX_W+1)'(NUM_REQ)) begin
            pos = pos - (IDX_W+1)'(NUM_REQ);
         end
         if (!grant_valid && cand[pos[IDX_W-1:0]]) begin
            grant_valid = 1'b1;
            grant_idx   = pos[IDX_W-1:0];
         end
      end
      if (grant_valid) begin
         grant[grant_idx] = 1'b1;
      end
   end

endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: shares the single CDB writeback port among NUM_REQ result
// producers. Each requester owns a one-entry slot; a round-robin arbiter
// loads one candidate per cycle into a registered output stage that follows
// the wb_valid/wb_ready handshake. Flush empties everything; squash drops
// entries whose epoch differs from live_epoch.
// Optional feature macro: CDB_MISPRED_PRIO_EN (mispredicting results win
// over round-robin order).
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   req_valid/req_ready        per-requester handshake
//   req_rob_idx/epoch/mispredict/pd/data   flattened per-requester fields
//   wb_valid/wb_ready          CDB broadcast handshake
//   wb_rob_idx/epoch/mispredict/pd/data    broadcast fields
//   flush_valid, squash_valid, live_epoch  invalidation controls
//   busy                       any slot or the output stage occupied
module cdb_arbiter #(
   parameter int unsigned NUM_REQ = cdb_pkg::FU_NUM,
   parameter int unsigned ROB_W   = cdb_pkg::ROB_W,
   parameter int unsigned PHYS_W  = cdb_pkg::PHYS_W,
   parameter int unsigned DW      = cdb_pkg::DW
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_REQ-1:0]        req_valid,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic [NUM_REQ*ROB_W-1:0]  req_rob_idx,
   input  logic [NUM_REQ*2-1:0]      req_epoch,
   input  logic [NUM_REQ-1:0]        req_mispredict,
   input  logic [NUM_REQ*PHYS_W-1:0] req_pd,
   input  logic [NUM_REQ*DW-1:0]     req_data,
   output logic                      wb_valid,
   input  logic                      wb_ready,
   output logic [ROB_W-1:0]          wb_rob_idx,
   output logic [1:0]                wb_epoch,
   output logic                      wb_mispredict,
   output logic [PHYS_W-1:0]         wb_pd,
   output logic [DW-1:0]             wb_data,
   input  logic                      flush_valid,
   input  logic                      squash_valid,
   input  logic [1:0]                live_epoch,
   output logic                      busy
);

   import cdb_pkg::*;

   localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef struct packed {
      logic [ROB_W-1:0]  rob_idx;
      logic [1:0]        epoch;
      logic              mispredict;
      logic [PHYS_W-1:0] pd;
      logic [DW-1:0]     data;
   } pkt_t;

   out_state_t         out_state, out_state_nx;
   pkt_t               out_pkt, out_pkt_nx;

   logic [NUM_REQ-1:0] slot_vld, slot_vld_nx, slot_load;
   pkt_t               slot_pkt [NUM_REQ];
   pkt_t               in_pkt   [NUM_REQ];
   pkt_t               cand_pkt [NUM_REQ];

   logic [NUM_REQ-1:0] slot_stale, in_stale, cand_vld, capture;
   logic [NUM_REQ-1:0] arb_req, arb_prio, grant;
   logic [IDX_W-1:0]   rr_ptr, grant_idx;
   logic               grant_valid;
   logic               out_fire, out_free;

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_in
      assign in_pkt[g] = '{rob_idx:    req_rob_idx[g*ROB_W +: ROB_W],
                           epoch:      req_epoch[g*2 +: 2],
                           mispredict: req_mispredict[g],
                           pd:         req_pd[g*PHYS_W +: PHYS_W],
                           data:       req_data[g*DW +: DW]};
   end

   assign wb_valid = (out_state == OUT_FULL);
   assign out_fire = wb_valid && wb_ready;
   assign out_free = (out_state == OUT_EMPTY) || out_fire;
   assign busy     = (slot_vld != '0) || wb_valid;

   assign wb_rob_idx    = out_pkt.rob_idx;
   assign wb_epoch      = out_pkt.epoch;
   assign wb_mispredict = out_pkt.mispredict;
   assign wb_pd         = out_pkt.pd;
   assign wb_data       = out_pkt.data;

   // An empty slot offers the incoming request directly, so an uncontested
   // result reaches the output stage without first parking in its slot.
   always_comb begin
      slot_stale = '0;
      in_stale   = '0;
      cand_vld   = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         slot_stale[i] = squash_valid && (slot_pkt[i].epoch != live_epoch);
         in_stale[i]   = squash_valid && (in_pkt[i].epoch != live_epoch);
         cand_pkt[i]   = slot_vld[i] ? slot_pkt[i] : in_pkt[i];
         cand_vld[i]   = slot_vld[i] ? !slot_stale[i]
                                     : (req_valid[i] && !in_stale[i]);
      end
   end

   assign arb_req = (out_free && !flush_valid) ? cand_vld : '0;

`ifdef CDB_MISPRED_PRIO_EN
   logic [NUM_REQ-1:0] cand_mp;
   always_comb begin
      cand_mp = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         cand_mp[i] = cand_pkt[i].mispredict;
      end
   end
   assign arb_prio = cand_mp;
`else
   assign arb_prio = '0;
`endif

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr (
      .req         (arb_req),
      .prio        (arb_prio),
      .ptr         (rr_ptr),
      .grant       (grant),
      .grant_idx   (grant_idx),
      .grant_valid (grant_valid)
   );

   assign req_ready = flush_valid ? '0 : (~slot_vld | grant);
   assign capture   = req_valid & req_ready;

   // Slot next state. A granted empty slot hands its input straight to the
   // output stage, so it stays empty; a stale capture is accepted and dropped.
   always_comb begin
      slot_vld_nx = '0;
      slot_load   = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (flush_valid) begin
            slot_vld_nx[i] = 1'b0;
         end else if (capture[i]) begin
            slot_load[i]   = 1'b1;
            slot_vld_nx[i] = !in_stale[i] && !(grant[i] && !slot_vld[i]);
         end else begin
            slot_vld_nx[i] = slot_vld[i] && !grant[i] && !slot_stale[i];
         end
      end
   end

   always_comb begin
      out_state_nx = out_state;
      out_pkt_nx   = out_pkt;
      if (flush_valid) begin
         out_state_nx = OUT_EMPTY;
      end else if (grant_valid) begin
         out_state_nx = OUT_FULL;
         out_pkt_nx   = cand_pkt[grant_idx];
      end else if (out_fire) begin
         out_state_nx = OUT_EMPTY;
      end else if (squash_valid && (out_pkt.epoch != live_epoch)) begin
         out_state_nx = OUT_EMPTY;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_state <= OUT_EMPTY;
         out_pkt   <= '0;
         rr_ptr    <= '0;
         slot_vld  <= '0;
         for (int unsigned i = 0; i < NUM_REQ; i++) begin
            slot_pkt[i] <= '0;
         end
      end else begin
         out_state <= out_state_nx;
         out_pkt   <= out_pkt_nx;
         slot_vld  <= slot_vld_nx;
         for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (slot_load[i]) begin
               slot_pkt[i] <= in_pkt[i];
            end
         end
         if (grant_valid) begin
            rr_ptr <= (grant_idx == IDX_W'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;
         end
      end
   end

endmodule
